// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds FSM state encodings, vector count, hold-counter width and SETTLE limit.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int NVEC       = 8;
    localparam int IDX_W      = 3;
    localparam int ERR_W      = 4;
    localparam int CNT_W      = 4;
    localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/tt_sweeper_if.sv
// Sweep control/status bundle between a requester and the sweeper.
// master: drives start/abort/golden/ans; slave: drives stimulus and results.
interface tt_sweeper_if;

    logic                               start;
    logic                               abort;
    logic [tt_sweep_pkg::NVEC-1:0]      golden;
    logic                               ans;
    logic                               inA;
    logic                               inB;
    logic                               inC;
    logic                               busy;
    logic                               done;
    logic                               pass;
    logic [tt_sweep_pkg::ERR_W-1:0]     err_count;
    logic [tt_sweep_pkg::IDX_W-1:0]     first_err_idx;

    modport master (
        output start, abort, golden, ans,
        input  inA, inB, inC, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        input  start, abort, golden, ans,
        output inA, inB, inC, busy, done, pass, err_count, first_err_idx
    );

endinterface

// File: rtl/settle_cnt.sv
// Hold counter: load a value, decrement on request, flag when zero.
// Ports: clk, rst_n, load_i, load_val_i, dec_i, zero_o.
module settle_cnt
    import tt_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweeper.sv
// Truth-table sweeper: drives all 8 input vectors, compares ans with golden.
// Ports: clk, rst_n, bus (slave) carrying start/abort/golden/ans and results.
module tt_sweeper
    import tt_sweep_pkg::*;
#(
    // Hold cycles per vector before sampling; legal 1..MAX_SETTLE.
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    tt_sweeper_if.slave bus
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NVEC - 1);

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        stim_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [IDX_W-1:0]  first_q;

    logic              go;
    logic              kill;
    logic              mism;
    logic [ERR_W-1:0]  err_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    always_comb begin
        go       = bus.start &&
                   (state_q == S_IDLE || state_q == S_DONE);
        kill     = bus.abort &&
                   (state_q == S_DRIVE || state_q == S_SAMPLE);
        mism     = (bus.ans != bus.golden[idx_q]);
        err_d    = err_q + {{(ERR_W-1){1'b0}}, mism};
        // Reload on a new sweep and on every step to the next vector.
        cnt_load = go ||
                   (state_q == S_SAMPLE && !kill && idx_q != LAST);
        cnt_dec  = (state_q == S_DRIVE) && !kill && !cnt_zero;
    end

    settle_cnt u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (RELOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state_q <= S_DRIVE;
                        idx_q   <= '0;
                        stim_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                    end
                end
                S_DRIVE: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                        stim_q  <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                    end else if (cnt_zero) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (kill) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                        stim_q  <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                    end else begin
                        err_q <= err_d;
                        if (mism && err_q == '0) begin
                            first_q <= idx_q;
                        end
                        if (idx_q == LAST) begin
                            // Stimulus stays at the last vector.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= S_DRIVE;
                            idx_q   <= idx_q + 1'b1;
                            stim_q  <= idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.inA           = stim_q[2];
    assign bus.inB           = stim_q[1];
    assign bus.inC           = stim_q[0];
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;

endmodule

// File: doc/tt_sweeper.md
TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 Parameter SETTLE, default 2: cycles each input vector is held before ans is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 golden  input  8  expected truth table; golden[i] is the expected ans for vector i, where i = {inA,inB,inC}.
REQ-007 ans  input  1  response from the DUT under sweep.
REQ-008 inA, inB, inC  output  1 each  registered stimulus to the DUT.
REQ-009 busy  output  1  high in DRIVE or SAMPLE.
REQ-010 done  output  1  high in DONE only.
REQ-011 pass  output  1  valid while done is high; 1 when err_count == 0.
REQ-012 err_count  output  4  number of mismatching vectors, 0..8.
REQ-013 first_err_idx  output  3  index of the first mismatching vector; valid when err_count != 0.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE -> DRIVE on start: idx <= 0, err_count <= 0, settle counter <= SETTLE-1, {inA,inB,inC} <= 3'b000.
REQ-016 In DRIVE, {inA,inB,inC} equals idx and the counter decrements each cycle; at counter 0, DRIVE -> SAMPLE.
REQ-017 In SAMPLE, ans is compared with golden[idx] at the edge that leaves SAMPLE; on mismatch err_count increments, and first_err_idx <= idx if err_count was 0.
REQ-018 SAMPLE with idx < 7 -> DRIVE: idx increments, counter reloads to SETTLE-1, and the outputs present the new idx on the next cycle.
REQ-019 SAMPLE with idx == 7 -> DONE; idx does not wrap and the stimulus holds 3'b111.
REQ-020 Each vector occupies exactly SETTLE+1 cycles. Start accepted at edge k -> first DRIVE cycle k+1 -> done rises at cycle k+1+8*(SETTLE+1).
REQ-021 DONE holds err_count, first_err_idx and pass stable until start.
REQ-022 start in DONE behaves as start in IDLE (REQ-015).
REQ-023 start while busy is ignored.
REQ-024 abort while busy -> IDLE next cycle: stimulus 3'b000, err_count 0, done 0.
REQ-025 abort in IDLE or DONE is ignored.
REQ-026 abort and start asserted in the same cycle: abort wins when busy; start wins in IDLE or DONE.
REQ-027 err_count saturates at 8 by construction and never wraps.

Reset
REQ-028 rst_n low forces immediately, without waiting for clk: state IDLE, idx 0, counter 0, inA/inB/inC 0, busy 0, done 0, pass 0, err_count 0, first_err_idx 0.
REQ-029 Reset asserted mid-sweep discards all partial results.
REQ-030 After rst_n deasserts, the block stays in IDLE until a start is sampled.

Structure
REQ-031 State encodings, the vector count (8) and the maximum SETTLE (15) live in the shared package/header tt_sweep_pkg.
REQ-032 The hold counter is one sub-module, settle_cnt: load, decrement and zero flag, 4 bits wide.
REQ-033 All outputs come directly from registers; there is no combinational path from ans or start to any output.

Verification
REQ-034 SETTLE=2, golden matches the DUT, start pulse at cycle 0 -> busy at cycle 1, done at cycle 25, pass=1, err_count=0.
REQ-035 golden with bit 5 inverted -> err_count=1, first_err_idx=5, pass=0.
REQ-036 golden fully inverted -> err_count=8, first_err_idx=0.
REQ-037 abort during idx=3 -> IDLE next cycle, outputs 3'b000, done never rises; a new start then completes normally.
REQ-038 rst_n low mid-SAMPLE at idx=6, then start -> all outputs 0 immediately, then a full clean sweep with correct counts.
REQ-039 start pulsed at idx=4 while busy -> no restart, done still at cycle 25; a second start in DONE reruns the sweep.
